ast_packet_arbiter: RTL

- Shares one Avalon-ST width-converter input (DATA_IN_W side) among N_SRC packet sources.
- Round-robin arbitration at packet granularity: a granted source owns the converter from its first accepted beat until its endofpacket beat is accepted.
- A single registered output stage drives the converter. channel/empty pass through unchanged.

---
 rtl/ast_packet_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/ast_packet_arbiter.sv
// ast_packet_arbiter
//   Shares one Avalon-ST sink (the input of a width converter) among N_SRC packet
//   sources. Arbitration is round-robin at packet granularity: once a source is
//   granted it owns the sink until its endofpacket beat has been accepted. Beats
//   are forwarded through a single registered output stage; channel and empty
//   pass through unchanged.
//
// Ports
//   clk_i                clock
//   srst_i               synchronous active-high reset
//   ast_data_i           per-source data, source i at [i*DATA_IN_W +: DATA_IN_W]
//   ast_startofpacket_i  per-source sop
//   ast_endofpacket_i    per-source eop
//   ast_valid_i          per-source valid
//   ast_empty_i          per-source empty, source i at [i*EMPTY_IN_W +: EMPTY_IN_W]
//   ast_channel_i        per-source channel, source i at [i*CHANNEL_W +: CHANNEL_W]
//   ast_ready_o          per-source ready (only the granted source can see 1)
//   ast_data_o .. ast_channel_o, ast_valid_o
//                        registered beat towards the converter
//   ast_ready_i          converter ready
//   grant_o              one-hot current owner, 0 while idle
//   busy_o               high while a source owns the converter
module ast_packet_arbiter #(
    parameter int unsigned N_SRC      = 4,
    parameter int unsigned DATA_IN_W  = 64,
    parameter int unsigned CHANNEL_W  = 10,
    parameter int unsigned EMPTY_IN_W = (DATA_IN_W / 8 > 1) ? $clog2(DATA_IN_W / 8) : 1,
    parameter int unsigned IDX_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                        clk_i,
    input  logic                        srst_i,

    input  logic [N_SRC*DATA_IN_W-1:0]  ast_data_i,
    input  logic [N_SRC-1:0]            ast_startofpacket_i,
    input  logic [N_SRC-1:0]            ast_endofpacket_i,
    input  logic [N_SRC-1:0]            ast_valid_i,
    input  logic [N_SRC*EMPTY_IN_W-1:0] ast_empty_i,
    input  logic [N_SRC*CHANNEL_W-1:0]  ast_channel_i,
    output logic [N_SRC-1:0]            ast_ready_o,

    output logic [DATA_IN_W-1:0]        ast_data_o,
    output logic                        ast_startofpacket_o,
    output logic                        ast_endofpacket_o,
    output logic                        ast_valid_o,
    output logic [EMPTY_IN_W-1:0]       ast_empty_o,
    output logic [CHANNEL_W-1:0]        ast_channel_o,
    input  logic                        ast_ready_i,

    output logic [N_SRC-1:0]            grant_o,
    output logic                        busy_o
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StBusy = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      gidx_q, gidx_d;
    logic [N_SRC-1:0]      grant_q, grant_d;

    logic [DATA_IN_W-1:0]  data_q;
    logic                  sop_q;
    logic                  eop_q;
    logic                  valid_q;
    logic [EMPTY_IN_W-1:0] empty_q;
    logic [CHANNEL_W-1:0]  channel_q;

    // Fields of the currently granted source.
    logic [DATA_IN_W-1:0]  sel_data;
    logic                  sel_sop;
    logic                  sel_eop;
    logic                  sel_valid;
    logic [EMPTY_IN_W-1:0] sel_empty;
    logic [CHANNEL_W-1:0]  sel_channel;

    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W-1:0]      rr_inc;
    logic                  out_free;
    logic                  accept;
    logic                  release_pkt;

    // Round-robin pick: first valid source at or after rr_ptr, with wrap-around.
    // The loop runs from the farthest candidate down so the nearest one wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
            int cand;
            cand = (int'(rr_ptr_q) + k) % int'(N_SRC);
            if (ast_valid_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // Source multiplexer driven by the registered grant index.
    always_comb begin
        sel_data    = '0;
        sel_sop     = 1'b0;
        sel_eop     = 1'b0;
        sel_valid   = 1'b0;
        sel_empty   = '0;
        sel_channel = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (gidx_q == IDX_W'(i)) begin
                sel_data    = ast_data_i[i*DATA_IN_W +: DATA_IN_W];
                sel_sop     = ast_startofpacket_i[i];
                sel_eop     = ast_endofpacket_i[i];
                sel_valid   = ast_valid_i[i];
                sel_empty   = ast_empty_i[i*EMPTY_IN_W +: EMPTY_IN_W];
                sel_channel = ast_channel_i[i*CHANNEL_W +: CHANNEL_W];
            end
        end
    end

    // The output register can take a new beat when it is empty or being drained.
    assign out_free    = !valid_q || ast_ready_i;
    assign accept      = (state_q == StBusy) && sel_valid && out_free;
    // Release follows source-side acceptance of eop, not converter consumption.
    assign release_pkt = accept && sel_eop;
    assign rr_inc      = (int'(gidx_q) == int'(N_SRC) - 1) ? '0 : gidx_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        grant_d  = grant_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d = StBusy;
                    gidx_d  = pick_idx;
                    for (int i = 0; i < int'(N_SRC); i++) begin
                        grant_d[i] = (pick_idx == IDX_W'(i));
                    end
                end
            end
            StBusy: begin
                if (release_pkt) begin
                    state_d  = StIdle;
                    grant_d  = '0;
                    rr_ptr_d = rr_inc;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
        end
    end

    // Output stage: load on accept, drop valid once consumed, otherwise hold.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            data_q    <= '0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            valid_q   <= 1'b0;
            empty_q   <= '0;
            channel_q <= '0;
        end else if (accept) begin
            data_q    <= sel_data;
            sop_q     <= sel_sop;
            eop_q     <= sel_eop;
            valid_q   <= 1'b1;
            empty_q   <= sel_empty;
            channel_q <= sel_channel;
        end else if (ast_ready_i) begin
            valid_q   <= 1'b0;
        end
    end

    // grant_q is zero while idle, so this also keeps every ready low in IDLE.
    assign ast_ready_o         = grant_q & {N_SRC{out_free}};

    assign ast_data_o          = data_q;
    assign ast_startofpacket_o = sop_q;
    assign ast_endofpacket_o   = eop_q;
    assign ast_valid_o         = valid_q;
    assign ast_empty_o         = empty_q;
    assign ast_channel_o       = channel_q;

    assign grant_o             = grant_q;
    assign busy_o              = (state_q == StBusy);

endmodule
